pipe_flush_ctrl: RTL and testbench

Central stall/flush sequencer for the dual-issue pipeline. Merges per-stage stall requests into the 6-bit stall vector, arbitrates exception vs. branch-misprediction flushes, and drives the PC redirect. When a redirect arrives while an instruction-cache fetch cannot be aborted, it holds the redirect pending until the fetch drains. It sits beside the pipeline registers (if_id, id_ex, ...) and the PC register, and feeds all of them.

---
 rtl/pipe_flush_ctrl_pkg.sv | 20 ++
 rtl/pipe_flush_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_flush_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pipe_flush_ctrl_pkg.sv
// rtl/pipe_flush_ctrl_pkg.sv - shared stall/flush encodings for the pipeline control path
package pipe_flush_ctrl_pkg;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic FLUSH    = 1'b1;
    localparam logic NO_FLUSH = 1'b0;

    localparam logic EXCEPTION                = 1'b1;
    localparam logic FAILED_BRANCH_PREDICTION = 1'b0;

    // Stall vector: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

endpackage

// File: rtl/pipe_flush_ctrl.sv
// rtl/pipe_flush_ctrl.sv - stall merge, flush arbitration and PC redirect sequencer
module pipe_flush_ctrl
    import pipe_flush_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              exc_req_i,
    input  logic [ADDR_W-1:0] exc_target_i,
    input  logic              bp_fail_i,
    input  logic [ADDR_W-1:0] bp_target_i,
    output logic [5:0]        stall_o,
    output logic              flush_o,
    output logic              flush_cause_o,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] redirect_pc_o,
    output logic [CNT_W-1:0]  exc_cnt_o,
    output logic [CNT_W-1:0]  bpf_cnt_o
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pend_pc;
    logic [ADDR_W-1:0] w_pend_pc_nxt;
    logic [CNT_W-1:0]  r_exc_cnt;
    logic [CNT_W-1:0]  r_bpf_cnt;
    logic              w_exc_inc;
    logic              w_bpf_inc;
    logic              w_bpf_acc;
    logic [ADDR_W-1:0] w_target;

    // A mispredict seen under a mem stall is re-presented later, so it is not taken now.
    assign w_bpf_acc = bp_fail_i & ~exc_req_i & ~stallreq_mem;
    assign w_target  = exc_req_i ? exc_target_i : bp_target_i;

    always_comb begin
        w_state_nxt   = r_state;
        w_pend_pc_nxt = r_pend_pc;
        w_exc_inc     = 1'b0;
        w_bpf_inc     = 1'b0;
        stall_o       = STALL_NONE;
        flush_o       = NO_FLUSH;
        flush_cause_o = FAILED_BRANCH_PREDICTION;
        redirect_o    = 1'b0;
        redirect_pc_o = '0;
        if (!rst) begin
            case (r_state)
                ST_RUN: begin
                    if (exc_req_i || w_bpf_acc) begin
                        w_exc_inc     = exc_req_i;
                        w_bpf_inc     = w_bpf_acc;
                        flush_o       = FLUSH;
                        flush_cause_o = exc_req_i ? EXCEPTION : FAILED_BRANCH_PREDICTION;
                        if (!stallreq_if) begin
                            redirect_o    = 1'b1;
                            redirect_pc_o = w_target;
                        end else begin
                            stall_o       = STALL_IF;
                            w_pend_pc_nxt = w_target;
                            w_state_nxt   = ST_HOLD;
                        end
                    end else if (stallreq_mem) begin
                        stall_o = STALL_MEM;
                    end else if (stallreq_ex) begin
                        stall_o = STALL_EX;
                    end else if (stallreq_id) begin
                        stall_o = STALL_ID;
                    end else if (stallreq_if) begin
                        stall_o = STALL_IF;
                    end
                end
                ST_HOLD: begin
                    w_exc_inc = exc_req_i;
                    if (exc_req_i) begin
                        w_pend_pc_nxt = exc_target_i;
                    end
                    if (!stallreq_if) begin
                        // Flush here kills the stale fetch that returns in this cycle.
                        redirect_o    = 1'b1;
                        redirect_pc_o = exc_req_i ? exc_target_i : r_pend_pc;
                        flush_o       = FLUSH;
                        flush_cause_o = EXCEPTION;
                        w_state_nxt   = ST_RUN;
                    end else begin
                        stall_o = STALL_IF;
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_pend_pc <= '0;
            r_exc_cnt <= '0;
            r_bpf_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend_pc <= w_pend_pc_nxt;
            if (w_exc_inc) begin
                r_exc_cnt <= r_exc_cnt + CNT_W'(1);
            end
            if (w_bpf_inc) begin
                r_bpf_cnt <= r_bpf_cnt + CNT_W'(1);
            end
        end
    end

    assign exc_cnt_o = r_exc_cnt;
    assign bpf_cnt_o = r_bpf_cnt;

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// tb/tb_pipe_flush_ctrl.sv - scoreboard bench for pipe_flush_ctrl with a behavioural model
module tb_pipe_flush_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        exc_req_i;
    logic [31:0] exc_target_i;
    logic        bp_fail_i;
    logic [31:0] bp_target_i;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic        flush_cause_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic [31:0] exc_cnt_o;
    logic [31:0] bpf_cnt_o;

    pipe_flush_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .exc_req_i    (exc_req_i),
        .exc_target_i (exc_target_i),
        .bp_fail_i    (bp_fail_i),
        .bp_target_i  (bp_target_i),
        .stall_o      (stall_o),
        .flush_o      (flush_o),
        .flush_cause_o(flush_cause_o),
        .redirect_o   (redirect_o),
        .redirect_pc_o(redirect_pc_o),
        .exc_cnt_o    (exc_cnt_o),
        .bpf_cnt_o    (bpf_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic        cause;
        logic        redir;
        logic [31:0] pc;
        logic [31:0] ecnt;
        logic [31:0] bcnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Model: a pending redirect is just "a target waiting for the fetch to finish".
    bit          m_pending = 0;
    logic [31:0] m_target  = 0;
    int unsigned m_exc     = 0;
    int unsigned m_bpf     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("stall",    {26'd0, stall_o}, {26'd0, e.stall});
            chk("flush",    {31'd0, flush_o}, {31'd0, e.flush});
            chk("cause",    {31'd0, flush_cause_o}, {31'd0, e.cause});
            chk("redirect", {31'd0, redirect_o}, {31'd0, e.redir});
            chk("redir_pc", redirect_pc_o, e.pc);
            chk("exc_cnt",  exc_cnt_o, e.ecnt);
            chk("bpf_cnt",  bpf_cnt_o, e.bcnt);
        end
    end

    task automatic cyc(input bit r, input bit ifs, input bit ids, input bit exs, input bit mems,
                       input bit exc, input bit bpf, input logic [31:0] et, input logic [31:0] bt);
        exp_t e;
        int   depth;
        @(posedge clk);
        #1;
        rst = r; stallreq_if = ifs; stallreq_id = ids; stallreq_ex = exs; stallreq_mem = mems;
        exc_req_i = exc; bp_fail_i = bpf; exc_target_i = et; bp_target_i = bt;
        e.stall = 6'd0; e.flush = 0; e.cause = 0; e.redir = 0; e.pc = 32'd0;
        e.ecnt = m_exc; e.bcnt = m_bpf;
        if (r) begin
            m_pending = 0; m_target = 0; m_exc = 0; m_bpf = 0;
        end else if (m_pending) begin
            if (exc) begin
                m_target = et;
                m_exc++;
            end
            if (!ifs) begin
                e.redir = 1; e.pc = m_target; e.flush = 1; e.cause = 1;
                m_pending = 0;
            end else begin
                e.stall = 6'b000011;
            end
        end else if (exc || (bpf && !mems)) begin
            e.flush = 1;
            e.cause = exc;
            if (exc) m_exc++; else m_bpf++;
            if (!ifs) begin
                e.redir = 1; e.pc = exc ? et : bt;
            end else begin
                m_pending = 1; m_target = exc ? et : bt;
                e.stall = 6'b000011;
            end
        end else begin
            // Number of stopped stages, counting from the PC, is set by the oldest requester.
            depth = mems ? 5 : exs ? 4 : ids ? 3 : ifs ? 2 : 0;
            e.stall = 6'((1 << depth) - 1);
        end
        sb.push_back(e);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        exc_req_i = 0; bp_fail_i = 0; exc_target_i = 0; bp_target_i = 0;
        repeat (2) @(posedge clk);
        cyc(1, 1, 1, 1, 1, 1, 1, 32'h1234, 32'h5678);
        cyc(0, 1, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        idle();
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'hBFC00100);
        idle();
        cyc(0, 0, 0, 0, 0, 1, 1, 32'hBFC00380, 32'h8000_0040);
        idle();
        cyc(0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h8000_1000);
        repeat (3) cyc(0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h9999_0000);
        idle();
        cyc(0, 0, 0, 0, 1, 0, 1, 32'h0, 32'h8000_2000);
        idle();
        cyc(0, 1, 0, 0, 0, 0, 1, 32'h0, 32'h8000_3000);
        cyc(0, 1, 0, 0, 0, 1, 0, 32'h8000_0180, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 0, 32'h8000_0200, 32'h0);
        cyc(0, 1, 0, 0, 0, 1, 0, 32'h8000_0300, 32'h0);
        cyc(1, 1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        idle();
        idle();
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 3) == 0), $urandom, $urandom);
        end
        idle();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain actual=%0d required=0 entries left", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
